// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, in-order imem reads and a show-ahead {pc, instr} FIFO.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_FAULT = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    state_t          state_q, state_d;
    fq_entry_t       fq_mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, outstanding, drop;
    logic [31:0]     fetch_pc, rsp_pc;
    logic [31:0]     redir_pc;
    logic            redir_bad;
    logic            not_fault;
    logic            redir_take;
    logic            issue, rsp_fire, rsp_keep, pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misaligned_q;

    assign redir_pc   = redirect_pc;
    assign redir_bad  = redirect && (redirect_pc[1:0] != 2'b00);
    assign not_fault  = (state_q != S_FAULT);
    assign misaligned = misaligned_q;
`else
    logic            unused_redir_lsb;

    assign redir_pc         = {redirect_pc[31:2], 2'b00};
    assign redir_bad        = 1'b0;
    assign not_fault        = 1'b1;
    assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

    // Next state and request issue; credit covers buffered plus in-flight words.
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        imem_addr      = '0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redir_bad) state_d = S_FAULT;
`endif
            end
            S_RUN: begin
                imem_req_valid = !redirect && ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
                imem_addr      = fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redir_bad) state_d = S_FAULT;
`endif
            end
            default: state_d = state_q;
        endcase
    end

    assign redir_take = redirect && not_fault;
    assign issue      = imem_req_valid && imem_req_ready;
    assign rsp_fire   = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep   = rsp_fire && (drop == '0) && (state_q == S_RUN) && !redirect;
    assign pop        = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fq_mem[rd_ptr].instr : '0;
    assign instr_pc    = instr_valid ? fq_mem[rd_ptr].pc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Control counters and pointers; a redirect discards everything buffered or in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else if (redir_take) begin
            fetch_pc    <= redir_pc;
            rsp_pc      <= redir_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp_fire);
            drop        <= outstanding - CW'(rsp_fire);
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= misaligned_q | redir_bad;
`endif
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(issue) - CW'(rsp_fire);
            if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    // FIFO storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (rsp_keep) fq_mem[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
    end

endmodule
